simd_alu_result_sink: RTL
=========================

// Module: simd_alu_result_sink
// PURPOSE
//  Receiving end of the SIMD_ALU datapath: the issuer drives a/b/cin/opcode; this block reads the results.
//  Tracks each issued op through the ALU latency and captures {out, carry, tag} when the result is valid.
//  Derives per-lane zero flags and buffers results in a small FIFO drained by a valid/ready consumer.
//  Sits between SIMD_ALU and the result bus / writeback logic.
// PARAMETERS
//  LANES    4   SIMD lanes; each lane has 8-bit operands and a 16-bit result
//  RES_W    16  result width per lane (total result bus LANES*RES_W = 64)
//  ALU_LAT  1   cycles from issue_valid to a valid alu_out/alu_carry (1..4)
//  DEPTH    4   result FIFO entries (power of 2)
//  TAG_W    4   issue tag width
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high
//  issue_valid in  1      an op enters SIMD_ALU this cycle
//  issue_tag  in   TAG_W  tag of the issued op
//  alu_out    in   64     SIMD_ALU out; lane i = bits [16i+15:16i]
//  alu_carry  in   4      SIMD_ALU carry; bit i = lane i
//  m_valid    out  1      FIFO head is valid
//  m_ready    in   1      consumer accepts the head
//  m_data     out  64     head result
//  m_carry    out  4      head carry
//  m_zero     out  4      head per-lane zero flag (lane result == 0)
//  m_tag      out  TAG_W  head tag
//  inflight   out  3      ops issued but not yet captured (0..ALU_LAT)
//  overflow   out  1      sticky: a capture was dropped
//  drop_cnt   out  8      dropped captures, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; tag/valid delay line cleared; pointers 0. Applies immediately, mid-operation included.
//  Delay line: ALU_LAT stages of {valid, tag}. Stage ALU_LAT-1 valid marks the capture cycle;
//   the sink samples alu_out/alu_carry on that cycle's rising edge.
//  Capture: push {alu_out, alu_carry, zero, tag}, where zero[i] = ~|alu_out[16i+:16].
//  Head reaches m_* on the cycle after the capture edge (FIFO output is registered; no bypass).
//  Handshake: pop when m_valid & m_ready. m_data/m_tag/m_carry/m_zero hold while m_valid & !m_ready.
//  Full: a push with FIFO full and no pop in the same cycle is dropped. On a drop, set overflow and
//   increment drop_cnt (saturating). A push and a pop in the same cycle while full are both accepted.
//  Empty: m_valid = 0 and m_* hold their last values. A simultaneous push and pop while empty is not
//   possible, because m_valid is 0.
//  inflight: +1 on issue_valid, -1 at each capture (dropped captures included); both in one cycle = no change.
//  Pointers wrap modulo DEPTH; count occupies $clog2(DEPTH)+1 bits.
//  overflow and drop_cnt clear only on reset.
//  Back-to-back issue every cycle is supported at full throughput when m_ready = 1.
// STRUCTURE
//  simd_alu_pkg: LANES, LANE_OP_W = 8, RES_W, OPC_LANE_W = 4, and the
//   result_t struct {data[63:0], carry[3:0], zero[3:0], tag}.
//  Sub-module sync_fifo (WIDTH, DEPTH): registered-output FIFO with full/empty/count.
//  Top level contains the delay line, zero-flag logic, drop accounting and the inflight counter.
// TESTING
//  1 Reset released; issue_valid @c0 with tag 3; @c1 alu_out = 64'h0001_00FF_0000_1234, carry = 4'b1010
//    -> m_valid @c2, m_data equals alu_out, m_zero = 4'b0010, m_tag = 3.
//  2 m_ready = 0; issue 6 ops with tags 0..5 -> FIFO holds tags 0..3, overflow = 1, drop_cnt = 2;
//    then m_ready = 1 -> pops tags 0,1,2,3 in order.
//  3 FIFO full, m_ready = 1, a capture arrives -> pushed, no drop, count stays at 4.
//  4 Issue every cycle for 16 cycles with m_ready = 1 -> 16 results, in tag order, with no gaps;
//    inflight stays at 1.
//  5 reset asserted mid-burst with 2 ops in flight and 3 entries queued -> m_valid = 0, inflight = 0
//    and drop_cnt = 0 immediately (asynchronous); nothing captured after release.
//  6 ALU_LAT = 3 -> capture occurs 3 cycles after issue; alu_out = 64'h0 gives m_zero = 4'hF.

Source files
------------

// File: rtl/simd_alu_pkg.sv
// rtl/simd_alu_pkg.sv - shared widths, result record and lane zero-flag helper for the SIMD_ALU result path
package simd_alu_pkg;

  localparam int LANES      = 4;
  localparam int LANE_OP_W  = 8;
  localparam int RES_W      = 2 * LANE_OP_W;
  localparam int OPC_LANE_W = 4;
  localparam int TAG_W      = 4;
  localparam int DATA_W     = LANES * RES_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  carry;
    logic [LANES-1:0]  zero;
    logic [TAG_W-1:0]  tag;
  } result_t;

  function automatic logic [LANES-1:0] lane_zero(input logic [DATA_W-1:0] d);
    logic [LANES-1:0] z;
    for (int i = 0; i < LANES; i++) begin
      z[i] = ~|d[i*RES_W +: RES_W];
    end
    return z;
  endfunction

endpackage

// File: rtl/simd_alu_result_sink_fifo.sv
// rtl/simd_alu_result_sink_fifo.sv - registered-output synchronous FIFO with full flag and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pop_ok, push_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = rdata_q;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    rdata_d  = rdata_q;
    // Output register reloads only when the head changes; the new head is the incoming word
    // exactly when the read pointer lands on the slot being written this cycle.
    if ((count_d != '0) && (pop_ok || (count_q == '0))) begin
      rdata_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? wdata : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/simd_alu_result_sink.sv
// rtl/simd_alu_result_sink.sv - tracks issued ALU ops through their latency, captures results and queues them
module simd_alu_result_sink
  import simd_alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [TAG_W-1:0]     issue_tag,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic [LANES-1:0]     alu_carry,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [LANES-1:0]     m_carry,
  output logic [LANES-1:0]     m_zero,
  output logic [TAG_W-1:0]     m_tag,
  output logic [2:0]           inflight,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  logic [ALU_LAT-1:0]            dl_vld_q, dl_vld_d;
  logic [ALU_LAT-1:0][TAG_W-1:0] dl_tag_q, dl_tag_d;
  logic [2:0]                    inflight_q, inflight_d;
  logic                          overflow_q, overflow_d;
  logic [7:0]                    drop_cnt_q, drop_cnt_d;

  logic                          capture, pop, drop, fifo_full;
  logic [$clog2(DEPTH):0]        fifo_count;
  result_t                       wr_res, rd_res;

  assign capture = dl_vld_q[ALU_LAT-1];
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign drop    = capture && fifo_full && !pop;

  always_comb begin
    wr_res.data  = alu_out;
    wr_res.carry = alu_carry;
    wr_res.zero  = lane_zero(alu_out);
    wr_res.tag   = dl_tag_q[ALU_LAT-1];
  end

  sync_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .wdata (wr_res),
    .pop   (pop),
    .rdata (rd_res),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign m_data   = rd_res.data;
  assign m_carry  = rd_res.carry;
  assign m_zero   = rd_res.zero;
  assign m_tag    = rd_res.tag;
  assign inflight = inflight_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    dl_vld_d[0] = issue_valid;
    dl_tag_d[0] = issue_tag;
    for (int i = 1; i < ALU_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
    // Dropped captures still retire from the in-flight count.
    inflight_d = inflight_q + 3'(issue_valid) - 3'(capture);
    overflow_d = overflow_q || drop;
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_vld_q   <= '0;
      dl_tag_q   <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      dl_vld_q   <= dl_vld_d;
      dl_tag_q   <= dl_tag_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
